clap_command_fsm: RTL and testbench

Controller downstream of the clap detector. It consumes single-cycle clap pulses and groups them into sequences of 1..MAX_CLAPS claps, using an inter-clap gap window. For each completed sequence it emits one command pulse carrying the clap count, flips a per-command toggle output, then enters a lockout period so echoes are not counted. It sits between the clap detector and the board LEDs/actuators.

---
 rtl/clap_command_fsm_if.sv | 36 +++
 rtl/clap_command_fsm.sv | 146 ++++++++++++++
 tb/tb_clap_command_fsm.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clap_command_fsm_if.sv
// Clap-controller handshake bundle: detector strobe and enable in, command/toggle/status out.
// Latency: none (wires only).
// Backpressure: none; the command strobe is fire-and-forget and the sink must sample it every cycle.
interface clap_command_fsm_if #(
   parameter int MAX_CLAPS = 3
);
   logic                 clap_pulse_i;
   logic                 enable_i;
   logic                 cmd_valid_o;
   logic [1:0]           cmd_count_o;
   logic [MAX_CLAPS-1:0] toggle_o;
   logic                 busy_o;
   logic [1:0]           state_o;

   // Upstream side: the clap detector and enable source, which also observe the results
   modport master (
      output clap_pulse_i,
      output enable_i,
      input  cmd_valid_o,
      input  cmd_count_o,
      input  toggle_o,
      input  busy_o,
      input  state_o
   );

   // Controller side
   modport slave (
      input  clap_pulse_i,
      input  enable_i,
      output cmd_valid_o,
      output cmd_count_o,
      output toggle_o,
      output busy_o,
      output state_o
   );
endinterface

// File: rtl/clap_command_fsm.sv
// Groups clap pulses into sequences of 1..MAX_CLAPS claps and emits one counted command per sequence, then locks out echoes.
// Latency: the command strobe follows the edge that samples the last clap by GAP_MAX cycles, or by zero cycles when that clap reaches MAX_CLAPS.
// Backpressure: none; claps that arrive during the command cycle or the lockout are dropped.
module clap_command_fsm #(
   parameter int GAP_MAX   = 50_000_000,
   parameter int LOCKOUT   = 20_000_000,
   parameter int MAX_CLAPS = 3
) (
   input  logic                 M_CLK,
   input  logic                 rst_n_i,
   clap_command_fsm_if.slave    bus
);

   // The gap window and the lockout never run at the same time, so they share one timer
   localparam int TIMER_MAX = (GAP_MAX > LOCKOUT) ? GAP_MAX : LOCKOUT;
   localparam int TW        = $clog2(TIMER_MAX + 1);

   localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_MAX - 1);
   localparam logic [TW-1:0] LOCK_LAST  = TW'((LOCKOUT > 0) ? (LOCKOUT - 1) : 0);
   localparam logic [TW-1:0] TIMER_SAT  = {TW{1'b1}};
   localparam logic [1:0]    MAX_CNT    = 2'(MAX_CLAPS);
   localparam bit            HAS_LOCK   = (LOCKOUT > 0);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_EMIT    = 2'd2;
   localparam logic [1:0] S_LOCKOUT = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [1:0]           count_q, count_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [TW-1:0]        timer_inc;
   logic                 fire;
   logic [MAX_CLAPS-1:0] flip_mask;

   logic                 cmd_valid_q;
   logic [1:0]           cmd_count_q;
   logic [MAX_CLAPS-1:0] toggle_q;

   // Saturating increment so a long idle stretch can never wrap the timer back into range
   assign timer_inc = (timer_q == TIMER_SAT) ? timer_q : timer_q + 1'b1;

   // Next-state logic; a clap always outranks the gap timeout on the same edge
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      timer_d = timer_q;
      fire    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.clap_pulse_i && bus.enable_i) begin
               count_d = 2'd1;
               timer_d = '0;
               if (MAX_CNT == 2'd1) begin
                  state_d = S_EMIT;
                  fire    = 1'b1;
               end else begin
                  state_d = S_COLLECT;
               end
            end
         end
         S_COLLECT: begin
            if (!bus.enable_i) begin
               // Abort: the partial sequence is thrown away without a command
               state_d = S_IDLE;
               count_d = 2'd0;
               timer_d = '0;
            end else if (bus.clap_pulse_i) begin
               count_d = count_q + 2'd1;
               timer_d = '0;
               if (count_d == MAX_CNT) begin
                  state_d = S_EMIT;
                  fire    = 1'b1;
               end
            end else if (timer_q == GAP_LAST) begin
               state_d = S_EMIT;
               fire    = 1'b1;
            end else begin
               timer_d = timer_inc;
            end
         end
         S_EMIT: begin
            // The command left on entry; this cycle only clears the sequence
            count_d = 2'd0;
            timer_d = '0;
            state_d = HAS_LOCK ? S_LOCKOUT : S_IDLE;
         end
         S_LOCKOUT: begin
            if (timer_q == LOCK_LAST) begin
               state_d = S_IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_inc;
            end
         end
         default: begin
            state_d = S_IDLE;
            count_d = 2'd0;
            timer_d = '0;
         end
      endcase
   end

   // One-hot mask of the toggle bit owned by the count being emitted
   always_comb begin
      flip_mask = '0;
      for (int i = 0; i < MAX_CLAPS; i++) begin
         flip_mask[i] = fire && (count_d == 2'(i + 1));
      end
   end

   // Sequence state registers
   always_ff @(posedge M_CLK or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         count_q <= 2'd0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         timer_q <= timer_d;
      end
   end

   // Command outputs are registered on the edge that enters EMIT; the count holds between commands
   always_ff @(posedge M_CLK or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cmd_valid_q <= 1'b0;
         cmd_count_q <= 2'd0;
         toggle_q    <= '0;
      end else begin
         cmd_valid_q <= fire;
         if (fire) begin
            cmd_count_q <= count_d;
         end
         toggle_q <= toggle_q ^ flip_mask;
      end
   end

   assign bus.cmd_valid_o = cmd_valid_q;
   assign bus.cmd_count_o = cmd_count_q;
   assign bus.toggle_o    = toggle_q;
   assign bus.busy_o      = (state_q != S_IDLE);
   assign bus.state_o     = state_q;

endmodule

// File: tb/tb_clap_command_fsm.sv
// Directed bench for clap_command_fsm with GAP_MAX=10, LOCKOUT=5, MAX_CLAPS=3.
// Latency: checks are taken 1 time unit after the rising edge under test.
// Backpressure: not applicable; stimulus is a fixed pulse schedule.
module tb_clap_command_fsm;
   localparam int GAP_MAX   = 10;
   localparam int LOCKOUT   = 5;
   localparam int MAX_CLAPS = 3;

   logic M_CLK;
   logic rst_n_i;
   int   n_checks;
   int   n_fail;

   clap_command_fsm_if #(.MAX_CLAPS(MAX_CLAPS)) bus ();

   clap_command_fsm #(
      .GAP_MAX  (GAP_MAX),
      .LOCKOUT  (LOCKOUT),
      .MAX_CLAPS(MAX_CLAPS)
   ) dut (
      .M_CLK  (M_CLK),
      .rst_n_i(rst_n_i),
      .bus    (bus)
   );

   // Packed view of every output: {cmd_valid, cmd_count[1:0], toggle[2:0], busy, state[1:0]}
   logic [8:0] obs;
   assign obs = {bus.cmd_valid_o, bus.cmd_count_o, bus.toggle_o, bus.busy_o, bus.state_o};

   initial M_CLK = 1'b0;
   always #5 M_CLK = ~M_CLK;

   task automatic tick(input int n);
      repeat (n) @(posedge M_CLK);
      #1;
   endtask

   // Clap sampled on the next rising edge; returns just after that edge
   task automatic pulse();
      bus.clap_pulse_i = 1'b1;
      tick(1);
      bus.clap_pulse_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n_i          = 1'b0;
      bus.clap_pulse_i = 1'b0;
      bus.enable_i     = 1'b1;
      #1;
      n_checks++;
      if (obs !== 9'b0_00_000_0_00) begin
         n_fail++;
         $display("FAIL reset_async: got %b required %b", obs, 9'b0_00_000_0_00);
      end
      // A clap while reset is held must not leak through
      bus.clap_pulse_i = 1'b1;
      tick(3);
      bus.clap_pulse_i = 1'b0;
      n_checks++;
      if (obs !== 9'b0_00_000_0_00) begin
         n_fail++;
         $display("FAIL reset_held: got %b required %b", obs, 9'b0_00_000_0_00);
      end
      #2 rst_n_i = 1'b1;
      tick(1);
      n_checks++;
      if (obs !== 9'b0_00_000_0_00) begin
         n_fail++;
         $display("FAIL reset_release: got %b required %b", obs, 9'b0_00_000_0_00);
      end
   endtask

   task automatic test_single_clap();
      pulse();
      n_checks++;
      if (obs !== 9'b0_00_000_1_01) begin
         n_fail++;
         $display("FAIL single_e0: got %b required %b", obs, 9'b0_00_000_1_01);
      end
      tick(9);
      n_checks++;
      if (obs !== 9'b0_00_000_1_01) begin
         n_fail++;
         $display("FAIL single_e9: got %b required %b", obs, 9'b0_00_000_1_01);
      end
      tick(1);
      n_checks++;
      if (obs !== 9'b1_01_001_1_10) begin
         n_fail++;
         $display("FAIL single_e10_cmd: got %b required %b", obs, 9'b1_01_001_1_10);
      end
      tick(1);
      n_checks++;
      if (obs !== 9'b0_01_001_1_11) begin
         n_fail++;
         $display("FAIL single_e11_lock: got %b required %b", obs, 9'b0_01_001_1_11);
      end
      tick(4);
      n_checks++;
      if (obs !== 9'b0_01_001_1_11) begin
         n_fail++;
         $display("FAIL single_e15_lock: got %b required %b", obs, 9'b0_01_001_1_11);
      end
      tick(1);
      n_checks++;
      if (obs !== 9'b0_01_001_0_00) begin
         n_fail++;
         $display("FAIL single_e16_idle: got %b required %b", obs, 9'b0_01_001_0_00);
      end
   endtask

   task automatic test_max_count();
      pulse();                 // edge 0
      tick(6);
      pulse();                 // edge 7
      n_checks++;
      if (obs !== 9'b0_01_001_1_01) begin
         n_fail++;
         $display("FAIL max_e7: got %b required %b", obs, 9'b0_01_001_1_01);
      end
      tick(8);
      n_checks++;
      if (obs !== 9'b0_01_001_1_01) begin
         n_fail++;
         $display("FAIL max_e15: got %b required %b", obs, 9'b0_01_001_1_01);
      end
      pulse();                 // edge 16: third clap fires immediately
      n_checks++;
      if (obs !== 9'b1_11_101_1_10) begin
         n_fail++;
         $display("FAIL max_e16_cmd: got %b required %b", obs, 9'b1_11_101_1_10);
      end
      tick(2);
      pulse();                 // edge 19: inside lockout, ignored
      n_checks++;
      if (obs !== 9'b0_11_101_1_11) begin
         n_fail++;
         $display("FAIL max_e19_ignored: got %b required %b", obs, 9'b0_11_101_1_11);
      end
      tick(3);
      n_checks++;
      if (obs !== 9'b0_11_101_0_00) begin
         n_fail++;
         $display("FAIL max_e22_idle: got %b required %b", obs, 9'b0_11_101_0_00);
      end
      pulse();                 // edge 23: first IDLE cycle, accepted
      n_checks++;
      if (obs !== 9'b0_11_101_1_01) begin
         n_fail++;
         $display("FAIL max_e23_new_seq: got %b required %b", obs, 9'b0_11_101_1_01);
      end
      tick(9);
      n_checks++;
      if (obs !== 9'b0_11_101_1_01) begin
         n_fail++;
         $display("FAIL max_e32_count_held: got %b required %b", obs, 9'b0_11_101_1_01);
      end
      tick(1);                 // edge 33: second single-clap command flips toggle[0] back
      n_checks++;
      if (obs !== 9'b1_01_100_1_10) begin
         n_fail++;
         $display("FAIL max_e33_toggle_back: got %b required %b", obs, 9'b1_01_100_1_10);
      end
      tick(1);
      n_checks++;
      if (bus.cmd_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL max_e34_strobe_single: got %b required %b", bus.cmd_valid_o, 1'b0);
      end
      tick(5);
      n_checks++;
      if (obs !== 9'b0_01_100_0_00) begin
         n_fail++;
         $display("FAIL max_e39_idle: got %b required %b", obs, 9'b0_01_100_0_00);
      end
   endtask

   task automatic test_timeout_tie();
      pulse();                 // edge 0
      tick(9);
      pulse();                 // edge 10: same edge as the timeout, clap wins
      n_checks++;
      if (obs !== 9'b0_01_100_1_01) begin
         n_fail++;
         $display("FAIL tie_e10_no_cmd: got %b required %b", obs, 9'b0_01_100_1_01);
      end
      tick(9);
      n_checks++;
      if (obs !== 9'b0_01_100_1_01) begin
         n_fail++;
         $display("FAIL tie_e19: got %b required %b", obs, 9'b0_01_100_1_01);
      end
      tick(1);
      n_checks++;
      if (obs !== 9'b1_10_110_1_10) begin
         n_fail++;
         $display("FAIL tie_e20_cmd: got %b required %b", obs, 9'b1_10_110_1_10);
      end
      tick(6);
      n_checks++;
      if (obs !== 9'b0_10_110_0_00) begin
         n_fail++;
         $display("FAIL tie_e26_idle: got %b required %b", obs, 9'b0_10_110_0_00);
      end
   endtask

   task automatic test_enable_abort();
      pulse();                 // edge 0
      tick(2);
      pulse();                 // edge 3
      n_checks++;
      if (obs !== 9'b0_10_110_1_01) begin
         n_fail++;
         $display("FAIL en_e3_collect: got %b required %b", obs, 9'b0_10_110_1_01);
      end
      tick(1);
      bus.enable_i = 1'b0;
      tick(1);                 // edge 5
      n_checks++;
      if (obs !== 9'b0_10_110_0_00) begin
         n_fail++;
         $display("FAIL en_e5_abort: got %b required %b", obs, 9'b0_10_110_0_00);
      end
      tick(2);
      pulse();                 // edge 8 with enable low
      n_checks++;
      if (obs !== 9'b0_10_110_0_00) begin
         n_fail++;
         $display("FAIL en_e8_ignored: got %b required %b", obs, 9'b0_10_110_0_00);
      end
      tick(12);
      n_checks++;
      if (obs !== 9'b0_10_110_0_00) begin
         n_fail++;
         $display("FAIL en_e20_quiet: got %b required %b", obs, 9'b0_10_110_0_00);
      end
      bus.enable_i = 1'b1;
   endtask

   task automatic test_async_reset();
      // Mid-COLLECT
      pulse();
      tick(3);
      #2 rst_n_i = 1'b0;
      #1;
      n_checks++;
      if (obs !== 9'b0_00_000_0_00) begin
         n_fail++;
         $display("FAIL arst_collect: got %b required %b", obs, 9'b0_00_000_0_00);
      end
      #1 rst_n_i = 1'b1;
      tick(1);
      // Mid-LOCKOUT, after a fresh single-clap command
      pulse();
      tick(10);
      n_checks++;
      if (obs !== 9'b1_01_001_1_10) begin
         n_fail++;
         $display("FAIL arst_fresh_cmd: got %b required %b", obs, 9'b1_01_001_1_10);
      end
      tick(2);
      n_checks++;
      if (obs !== 9'b0_01_001_1_11) begin
         n_fail++;
         $display("FAIL arst_pre_lock: got %b required %b", obs, 9'b0_01_001_1_11);
      end
      #2 rst_n_i = 1'b0;
      #1;
      n_checks++;
      if (obs !== 9'b0_00_000_0_00) begin
         n_fail++;
         $display("FAIL arst_lockout: got %b required %b", obs, 9'b0_00_000_0_00);
      end
      #1 rst_n_i = 1'b1;
      tick(1);
      // Back-to-back claps after release reach MAX_CLAPS on the third edge
      pulse();
      n_checks++;
      if (obs !== 9'b0_00_000_1_01) begin
         n_fail++;
         $display("FAIL arst_seq_e0: got %b required %b", obs, 9'b0_00_000_1_01);
      end
      pulse();
      pulse();
      n_checks++;
      if (obs !== 9'b1_11_100_1_10) begin
         n_fail++;
         $display("FAIL arst_seq_cmd: got %b required %b", obs, 9'b1_11_100_1_10);
      end
      tick(6);
      n_checks++;
      if (obs !== 9'b0_11_100_0_00) begin
         n_fail++;
         $display("FAIL arst_seq_idle: got %b required %b", obs, 9'b0_11_100_0_00);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_single_clap();
      test_max_count();
      test_timeout_tie();
      test_enable_abort();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
